// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: recovers the 8-bit duty value from a PWM line by counting
// high cycles between consecutive rising edges. It also flags periods of the
// wrong length and lines that stop toggling.
module pwm_duty_meter #(
    parameter int PERIOD  = 256,
    parameter int TIMEOUT = 512,
    parameter int CNT_W   = 10
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       pwm_in,
    output logic [7:0] speed_out,
    output logic       speed_valid,
    output logic       period_err,
    output logic       stuck
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] PERIOD_C  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] DUTY_MAX  = CNT_W'(255);

    state_t           state;
    logic             s1;
    logic             s2;
    logic             prev;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             rise;
    logic             timeout_hit;
    logic [7:0]       duty_val;

    assign rise        = s2 & ~prev;
    assign timeout_hit = (period_cnt == TIMEOUT_C);
    // A rise always follows at least one low sample, so the clamp never
    // engages on a correct-length period; it only guards odd parameter sets.
    assign duty_val    = (high_cnt > DUTY_MAX) ? 8'hFF : high_cnt[7:0];

    // Two-flop synchronizer plus the delayed copy used for edge detection.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= pwm_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    // Period and high-time counters: restart on each rise, saturate otherwise.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else if (rise) begin
            period_cnt <= CNT_W'(1);
            high_cnt   <= CNT_W'(1);
        end else begin
            if (period_cnt != CNT_MAX)
                period_cnt <= period_cnt + CNT_W'(1);
            if (s2 && (high_cnt != CNT_MAX))
                high_cnt <= high_cnt + CNT_W'(1);
        end
    end

    // Measurement FSM with registered outputs; a rise takes priority over timeout.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state       <= IDLE;
            speed_out   <= '0;
            speed_valid <= 1'b0;
            period_err  <= 1'b0;
            stuck       <= 1'b0;
        end else begin
            speed_valid <= 1'b0;
            if (rise) begin
                stuck <= 1'b0;
                case (state)
                    IDLE: begin
                        state <= MEASURE;
                    end
                    MEASURE: begin
                        if (period_cnt == PERIOD_C) begin
                            speed_out   <= duty_val;
                            speed_valid <= 1'b1;
                            period_err  <= 1'b0;
                        end else begin
                            period_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (timeout_hit) begin
                // Saturated counter moves past TIMEOUT, so this fires once per stall.
                stuck       <= 1'b1;
                speed_out   <= s2 ? 8'hFF : 8'h00;
                speed_valid <= 1'b1;
                state       <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Testbench for pwm_duty_meter: drives whole PWM periods and predicts the
// reported duty per period from a period-level model.
module tb_pwm_duty_meter;

    localparam int PERIOD  = 256;
    localparam int TIMEOUT = 512;

    logic       clk    = 1'b0;
    logic       arst   = 1'b0;
    logic       pwm_in = 1'b0;
    logic [7:0] speed_out;
    logic       speed_valid;
    logic       period_err;
    logic       stuck;

    int checks = 0;
    int errors = 0;

    // Period-level reference state
    bit         aligned   = 1'b0;
    int         pend_h    = 0;
    int         pend_p    = 0;
    logic [7:0] exp_speed = 8'd0;
    bit         exp_err   = 1'b0;
    bit         exp_stuck = 1'b0;
    bit         exp_valid = 1'b0;

    pwm_duty_meter #(
        .PERIOD (PERIOD),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (10)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .pwm_in     (pwm_in),
        .speed_out  (speed_out),
        .speed_valid(speed_valid),
        .period_err (period_err),
        .stuck      (stuck)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // A new rising edge closes the pending period: report it if it was measured.
    task automatic model_rise(input int h, input int p);
        exp_valid = 1'b0;
        if (aligned) begin
            if (pend_p == PERIOD) begin
                exp_valid = 1'b1;
                exp_speed = 8'(pend_h);
                exp_err   = 1'b0;
            end else begin
                exp_err = 1'b1;
            end
        end
        aligned   = 1'b1;
        exp_stuck = 1'b0;
        pend_h    = h;
        pend_p    = p;
    endtask

    task automatic model_reset();
        aligned   = 1'b0;
        exp_speed = 8'd0;
        exp_err   = 1'b0;
        exp_stuck = 1'b0;
        exp_valid = 1'b0;
    endtask

    // One PWM period: h high cycles then p-h low; result of the prior period seen at c==3.
    task automatic drive_period(input int h, input int p);
        model_rise(h, p);
        for (int c = 0; c < p; c++) begin
            @(negedge clk);
            checks++;
            if (speed_valid !== ((c == 3) && exp_valid)) begin
                errors++;
                if (errors < 40)
                    $display("FAIL valid_timing h=%0d p=%0d c=%0d got %0b exp %0b",
                             h, p, c, speed_valid, (c == 3) && exp_valid);
            end
            if (c == 3) begin
                checks++;
                if (speed_out !== exp_speed) begin
                    errors++;
                    $display("FAIL speed_out h=%0d p=%0d got %0d exp %0d", h, p, speed_out, exp_speed);
                end
                checks++;
                if (period_err !== exp_err) begin
                    errors++;
                    $display("FAIL period_err h=%0d p=%0d got %0b exp %0b", h, p, period_err, exp_err);
                end
                checks++;
                if (stuck !== exp_stuck) begin
                    errors++;
                    $display("FAIL stuck h=%0d p=%0d got %0b exp %0b", h, p, stuck, exp_stuck);
                end
            end
            pwm_in = (c < h);
        end
    endtask

    task automatic test_reset();
        arst   = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (speed_out !== 8'd0) begin errors++; $display("FAIL reset_speed got %0d exp 0", speed_out); end
        if (speed_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", speed_valid); end
        if (period_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", period_err); end
        if (stuck !== 1'b0) begin errors++; $display("FAIL reset_stuck got %0b exp 0", stuck); end
        arst = 1'b1;
        model_reset();
    endtask

    task automatic test_square();
        repeat (3) drive_period(128, 256);
    endtask

    task automatic test_duty_sweep();
        int duties[4] = '{1, 64, 200, 255};
        foreach (duties[i]) drive_period(duties[i], 256);
        drive_period(128, 256);
    endtask

    task automatic test_random();
        int h;
        int p;
        for (int n = 0; n < 24; n++) begin
            p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(240, 300)) : 256;
            h = int'($urandom_range(1, (p - 1 < 255) ? p - 1 : 255));
            drive_period(h, p);
        end
        drive_period(128, 256);
    endtask

    task automatic test_stuck_low();
        @(negedge clk);
        arst   = 1'b0;
        pwm_in = 1'b0;
        @(negedge clk);
        arst = 1'b1;
        model_reset();
        for (int c = 1; c <= TIMEOUT + 8; c++) begin
            @(negedge clk);
            checks++;
            if (speed_valid !== (c == TIMEOUT + 1)) begin
                errors++;
                $display("FAIL stuck_low_valid c=%0d got %0b exp %0b", c, speed_valid, c == TIMEOUT + 1);
            end
            if (c == TIMEOUT + 1) begin
                checks += 2;
                if (stuck !== 1'b1) begin errors++; $display("FAIL stuck_low_flag got %0b exp 1", stuck); end
                if (speed_out !== 8'd0) begin errors++; $display("FAIL stuck_low_speed got %0d exp 0", speed_out); end
            end
        end
        exp_stuck = 1'b1;
        exp_speed = 8'd0;
        repeat (3) drive_period(128, 256);
    endtask

    task automatic test_stuck_high();
        bit first_valid;
        model_rise(0, 0);
        first_valid = exp_valid;
        for (int c = 0; c < TIMEOUT + 200; c++) begin
            @(negedge clk);
            checks++;
            if (speed_valid !== (((c == 3) && first_valid) || (c == TIMEOUT + 3))) begin
                errors++;
                $display("FAIL stuck_high_valid c=%0d got %0b", c, speed_valid);
            end
            if (c == TIMEOUT + 3) begin
                checks += 2;
                if (stuck !== 1'b1) begin errors++; $display("FAIL stuck_high_flag got %0b exp 1", stuck); end
                if (speed_out !== 8'hFF) begin errors++; $display("FAIL stuck_high_speed got %0d exp 255", speed_out); end
            end
            pwm_in = 1'b1;
        end
        aligned   = 1'b0;
        exp_stuck = 1'b1;
        exp_speed = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            pwm_in = 1'b0;
        end
        repeat (3) drive_period(64, 256);
    endtask

    task automatic test_period_err();
        drive_period(100, 250);
        drive_period(100, 256);
        drive_period(128, 256);
        drive_period(128, 256);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (40) @(negedge clk);
        #2 arst = 1'b0;
        #1;
        checks += 4;
        if (speed_out !== 8'd0) begin errors++; $display("FAIL mid_reset_speed got %0d exp 0", speed_out); end
        if (speed_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %0b exp 0", speed_valid); end
        if (period_err !== 1'b0) begin errors++; $display("FAIL mid_reset_err got %0b exp 0", period_err); end
        if (stuck !== 1'b0) begin errors++; $display("FAIL mid_reset_stuck got %0b exp 0", stuck); end
        @(negedge clk);
        arst   = 1'b1;
        pwm_in = 1'b0;
        model_reset();
        repeat (3) drive_period(128, 256);
    endtask

    initial begin
        test_reset();
        test_square();
        test_duty_sweep();
        test_random();
        test_stuck_low();
        test_stuck_high();
        test_period_err();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
- Receive-side counterpart of the fan PWM generator. Samples a PWM line, the pwm_data produced by the fan-speed path.
- Measures high time per period and reports the recovered 8-bit duty (speed) value.
- Used for fan feedback and closed-loop checking of the cool/heat system.
- Flags period errors and stuck-high/stuck-low lines.

Parameters:
PERIOD, 256, expected PWM period in clk cycles (matches generator's 8-bit counter)
TIMEOUT, 512, cycles without a rising edge before the line is declared stuck (> PERIOD)
CNT_W, 10, width of internal period/high counters (must hold TIMEOUT)

Ports:
clk  input  1  clock, posedge
arst  input  1  asynchronous active-low reset (0 = reset)
pwm_in  input  1  PWM line, asynchronous to clk tolerated
speed_out  output  8  last recovered duty value (0..255)
speed_valid  output  1  one-cycle pulse when speed_out is updated
period_err  output  1  last measured period != PERIOD
stuck  output  1  no rising edge for TIMEOUT cycles

Behaviour:
- Reset (arst=0, async): speed_out=0, speed_valid=0, period_err=0, stuck=0, synchronizer flops=0, counters=0, state=IDLE. Reset mid-measurement discards the partial count. The first edge after release is treated as alignment only.
- Input path: 2-flop synchronizer s1->s2, then prev register.
  - rise = s2 & ~prev.
  - Raw edge sampled at clk edge k gives outputs registered at edge k+2 and visible through k+3. Total latency from edge sampling to speed_valid is 2 cycles.
- States: IDLE (waiting for alignment edge), MEASURE.
- Counting (both states):
  - On rise: period_cnt<=1, high_cnt<=1.
  - Otherwise: period_cnt+=1, saturating at 2^CNT_W-1; high_cnt+=s2, saturating.
- IDLE:
  - rise -> MEASURE, clear stuck, no speed update.
  - period_cnt==TIMEOUT -> stuck event (see below), stay IDLE.
- MEASURE, on rise:
  - If period_cnt==PERIOD: speed_out<=high_cnt (max 255, since a rise implies at least one low cycle), speed_valid<=1, period_err<=0.
  - Else: period_err<=1, speed_out holds, no valid pulse.
  - Stay in MEASURE; the counter restart is the same edge.
- Stuck event (period_cnt reaches TIMEOUT in either state):
  - stuck<=1.
  - speed_out<= (s2 ? 255 : 0), i.e. 100% saturates to 255.
  - speed_valid pulses once, period_err unchanged.
  - State -> IDLE. The saturated period_cnt prevents repeat events until the next rise.
- stuck clears on the first rise after it was set. period_err is sticky only until the next good period.
- speed_valid is never high two consecutive cycles.
- Glitches shorter than 1 clk may be missed. This is acceptable; no debounce.

Test Plan:
- Reset then pwm_in square wave 128 high/128 low -> first rise gives no output; second rise gives speed_out=128, speed_valid one cycle, 2 cycles after the synchronized edge; period_err=0.
- Duty sweep 1, 64, 200, 255 high cycles of 256 -> speed_out=1, 64, 200, 255 respectively, one valid per period, stuck=0.
- pwm_in held 0 after reset -> at cycle TIMEOUT (+2 sync): stuck=1, speed_out=0, single valid pulse. Apply square wave again -> stuck clears on the first rise, valid value on the second rise.
- pwm_in held 1 for >TIMEOUT cycles mid-operation -> stuck=1, speed_out=255, single valid pulse; no further pulses while held.
- Period 250 (100 high) -> period_err=1, speed_out keeps previous value, no valid. Return to 256 -> period_err=0, speed_out=100.
- Assert arst low mid-period with speed_out=128 -> all outputs 0 immediately (asynchronous). After release, the first rise is alignment only; the correct value arrives after one full period.
